food_placer: RTL and testbench

FOOD_PLACER -- requirements
Module: food_placer

---
 rtl/snake_pkg.sv | 19 +
 rtl/coord_in_range.sv | 25 ++
 rtl/food_placer.sv | 193 +++++++++++++++++++
 tb/tb_food_placer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared grid geometry and placer state encoding
// Purpose: default playfield size, coordinate widths and the food placer
//          state enumeration used by food_placer and coord_in_range.
// Ports:   none (package).
package snake_pkg;

  localparam int GRID_W_DEF = 160;
  localparam int GRID_H_DEF = 120;
  localparam int X_W        = 8;
  localparam int Y_W        = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAW   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_QUERY  = 2'd3
  } placer_state_t;

endpackage

// File: rtl/coord_in_range.sv
// rtl/coord_in_range.sv - combinational playfield bounds check
// Purpose: flags whether an (x, y) cell lies inside a GRID_W x GRID_H field.
// Ports:
//   x        in  X_W  column to test
//   y        in  Y_W  row to test
//   in_range out 1    1 = x < GRID_W and y < GRID_H (unsigned)
module coord_in_range
  import snake_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF
) (
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  output logic           in_range
);

  // Limits carry one extra bit so a full-width grid (256 / 128) still
  // compares correctly: every coordinate is then in range.
  localparam logic [X_W:0] LIM_X = (X_W + 1)'(GRID_W);
  localparam logic [Y_W:0] LIM_Y = (Y_W + 1)'(GRID_H);

  assign in_range = ({1'b0, x} < LIM_X) && ({1'b0, y} < LIM_Y);

endmodule

// File: rtl/food_placer.sv
// rtl/food_placer.sv - picks a random unoccupied cell for the next food item
// Purpose: on a place request, draws (rand_x, rand_y) from external LFSRs,
//          rejects out-of-field draws and cells occupied by the snake, and
//          publishes the first acceptable cell as the food position.
// Build option: FOOD_RETRY_LIMIT_EN - when defined, MAX_TRIES rejections
//          abort the search with a one-cycle fail pulse; when undefined the
//          search is unbounded and fail is tied low.
// Ports:
//   clk, reset         in   clock, synchronous active-high reset
//   place              in   single-cycle request (ignored while busy)
//   rand_x / rand_y    in   LFSR outputs (8 / 7 bits)
//   rand_ce            out  LFSR advance strobe, high only in DRAW
//   occ_req            out  occupancy query valid (QUERY state)
//   occ_x / occ_y      out  cell being queried, stable while occ_req
//   occ_ack / occ_hit  in   query done / cell occupied
//   food_x / food_y    out  last accepted food cell
//   food_valid         out  food_x/food_y hold an accepted cell
//   busy               out  FSM not idle
//   fail               out  one-cycle pulse when retries are exhausted
module food_placer
  import snake_pkg::*;
#(
  parameter int GRID_W    = GRID_W_DEF,
  parameter int GRID_H    = GRID_H_DEF,
  parameter int MAX_TRIES = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           place,
  input  logic [X_W-1:0] rand_x,
  input  logic [Y_W-1:0] rand_y,
  output logic           rand_ce,
  output logic           occ_req,
  output logic [X_W-1:0] occ_x,
  output logic [Y_W-1:0] occ_y,
  input  logic           occ_ack,
  input  logic           occ_hit,
  output logic [X_W-1:0] food_x,
  output logic [Y_W-1:0] food_y,
  output logic           food_valid,
  output logic           busy,
  output logic           fail
);

  if (GRID_W < 1 || GRID_W > 256) begin : g_bad_grid_w
    $error("food_placer: GRID_W must be 1..256");
  end
  if (GRID_H < 1 || GRID_H > 128) begin : g_bad_grid_h
    $error("food_placer: GRID_H must be 1..128");
  end
  if (MAX_TRIES < 1) begin : g_bad_max_tries
    $error("food_placer: MAX_TRIES must be at least 1");
  end

  placer_state_t state, state_next;

  logic           in_range;
  logic           start;
  logic           load_cand;
  logic           accept;
  logic           reject;
  logic           give_up;
  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;

  // Range check looks at the live LFSR outputs so SAMPLE can decide in the
  // same cycle it latches the candidate.
  coord_in_range #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_range (
    .x        (rand_x),
    .y        (rand_y),
    .in_range (in_range)
  );

`ifdef FOOD_RETRY_LIMIT_EN
  localparam int               TRY_W    = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
  localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);

  logic [TRY_W-1:0] try_cnt;
  logic             fail_q;

  // A rejection seen while the count is already MAX_TRIES-1 is the one
  // that brings it to MAX_TRIES.
  assign give_up = reject && (try_cnt >= TRY_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      try_cnt <= '0;
      fail_q  <= 1'b0;
    end else begin
      fail_q <= give_up;
      if (start) begin
        try_cnt <= '0;
      end else if (reject && (try_cnt != TRY_MAX)) begin
        try_cnt <= try_cnt + TRY_W'(1);
      end
    end
  end

  assign fail = fail_q;
`else
  assign give_up = 1'b0;
  assign fail    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rand_ce    = 1'b0;
    occ_req    = 1'b0;
    start      = 1'b0;
    load_cand  = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (place) begin
          start      = 1'b1;
          state_next = ST_DRAW;
        end
      end
      ST_DRAW: begin
        rand_ce    = 1'b1;
        state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        load_cand = 1'b1;
        if (!in_range) begin
          reject     = 1'b1;
          state_next = ST_DRAW;
        end else begin
          state_next = ST_QUERY;
        end
      end
      ST_QUERY: begin
        occ_req = 1'b1;
        if (occ_ack) begin
          if (occ_hit) begin
            reject     = 1'b1;
            state_next = ST_DRAW;
          end else begin
            accept     = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (give_up) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_x     <= '0;
      cand_y     <= '0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
    end else begin
      if (start) begin
        food_valid <= 1'b0;
      end
      if (load_cand) begin
        cand_x <= rand_x;
        cand_y <= rand_y;
      end
      if (accept) begin
        food_x     <= cand_x;
        food_y     <= cand_y;
        food_valid <= 1'b1;
      end
    end
  end

  // Candidate registers only change in SAMPLE, so the query address is
  // naturally stable for the whole QUERY wait.
  assign occ_x = cand_x;
  assign occ_y = cand_y;
  assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_food_placer.sv
// tb/tb_food_placer.sv - self-checking bench for food_placer
// Purpose: scripted LFSR draws and occupancy responses; expected food cells
//          are queued when stimulus is set up and compared on food_valid.
// Ports:   none (top-level bench).
module tb_food_placer;
  import snake_pkg::*;

  typedef struct {
    int x;
    int y;
  } cell_t;

  typedef struct {
    int x;
    int y;
    bit hit;
    int delay;
  } occ_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           place;
  logic [X_W-1:0] rand_x;
  logic [Y_W-1:0] rand_y;
  logic           rand_ce;
  logic           occ_req;
  logic [X_W-1:0] occ_x;
  logic [Y_W-1:0] occ_y;
  logic           occ_ack;
  logic           occ_hit;
  logic [X_W-1:0] food_x;
  logic [Y_W-1:0] food_y;
  logic           food_valid;
  logic           busy;
  logic           fail;

  cell_t draw_q[$];
  occ_t  occ_q[$];
  cell_t exp_q[$];

  int n_checks   = 0;
  int n_fail     = 0;
  int ce_cnt     = 0;
  int query_cnt  = 0;
  int fail_cnt   = 0;
  int fail_total = 0;
  int place_cnt  = 0;

  bit   prev_fv  = 1'b0;
  bit   prev_occ = 1'b0;
  bit   pending  = 1'b0;
  int   wait_cnt = 0;
  occ_t cur;

  always #5 clk = ~clk;

  food_placer #(
    .GRID_W    (160),
    .GRID_H    (120),
    .MAX_TRIES (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .place      (place),
    .rand_x     (rand_x),
    .rand_y     (rand_y),
    .rand_ce    (rand_ce),
    .occ_req    (occ_req),
    .occ_x      (occ_x),
    .occ_y      (occ_y),
    .occ_ack    (occ_ack),
    .occ_hit    (occ_hit),
    .food_x     (food_x),
    .food_y     (food_y),
    .food_valid (food_valid),
    .busy       (busy),
    .fail       (fail)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic add_draw(input int x, input int y);
    cell_t c;
    c.x = x;
    c.y = y;
    draw_q.push_back(c);
  endtask

  task automatic add_occ(input int x, input int y, input bit hit, input int delay);
    occ_t o;
    o.x     = x;
    o.y     = y;
    o.hit   = hit;
    o.delay = delay;
    occ_q.push_back(o);
  endtask

  task automatic add_exp(input int x, input int y);
    cell_t c;
    c.x = x;
    c.y = y;
    exp_q.push_back(c);
  endtask

  task automatic clear_counts();
    ce_cnt    = 0;
    query_cnt = 0;
    fail_cnt  = 0;
    place_cnt = 0;
  endtask

  // Pulses place for one cycle and waits (bounded) for the FSM to go idle.
  // lat counts edges from the one that samples place up to the one that
  // returns to idle, both inclusive.
  task automatic run_place(input string tag, output int lat);
    clear_counts();
    @(negedge clk);
    place = 1'b1;
    @(negedge clk);
    place = 1'b0;
    lat   = 1;
    while (busy && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_done"}, busy, 0);
  endtask

  // Monitor and LFSR / occupancy-store model, all at the falling edge:
  // outputs are sampled first, then the model's inputs are driven.
  initial begin
    forever begin
      cell_t d;
      cell_t e;
      @(negedge clk);
      if (rand_ce === 1'b1) ce_cnt++;
      if (fail === 1'b1) begin
        fail_cnt++;
        fail_total++;
      end
      if (food_valid === 1'b1 && !prev_fv) begin
        place_cnt++;
        if (exp_q.size() == 0) begin
          check("food_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("food_x", food_x, e.x);
          check("food_y", food_y, e.y);
        end
      end
      if (occ_req === 1'b1 && !prev_occ) begin
        query_cnt++;
        if (!pending) begin
          if (occ_q.size() == 0) begin
            check("occ_unexpected", 1, 0);
          end else begin
            cur      = occ_q.pop_front();
            pending  = 1'b1;
            wait_cnt = cur.delay;
          end
        end
      end
      if (occ_req === 1'b1 && pending) begin
        check("occ_x", occ_x, cur.x);
        check("occ_y", occ_y, cur.y);
      end
      prev_fv  = (food_valid === 1'b1);
      prev_occ = (occ_req === 1'b1);

      occ_ack = 1'b0;
      occ_hit = 1'b0;
      if (pending) begin
        if (wait_cnt == 0) begin
          occ_ack = 1'b1;
          occ_hit = cur.hit;
          pending = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
      if (rand_ce === 1'b1 && draw_q.size() > 0) begin
        d      = draw_q.pop_front();
        rand_x = X_W'(d.x);
        rand_y = Y_W'(d.y);
      end
    end
  end

  initial begin
    int lat;
    int n;
    reset   = 1'b1;
    place   = 1'b0;
    rand_x  = '0;
    rand_y  = '0;
    occ_ack = 1'b0;
    occ_hit = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_food_valid", food_valid, 0);
    check("rst_occ_req", occ_req, 0);
    check("rst_rand_ce", rand_ce, 0);
    check("rst_fail", fail, 0);
    check("rst_food_x", food_x, 0);
    check("rst_food_y", food_y, 0);
    check("rst_occ_x", occ_x, 0);

    // Fastest path: in-range first draw, free cell, immediate ack.
    add_draw(10, 20);
    add_occ(10, 20, 1'b0, 0);
    add_exp(10, 20);
    run_place("basic", lat);
    check("basic_latency", lat, 4);
    check("basic_food_valid", food_valid, 1);
    check("basic_ce", ce_cnt, 1);
    check("basic_query", query_cnt, 1);
    repeat (2) @(negedge clk);
    check("basic_hold_x", food_x, 10);

    // X out of range on the first draw: no query for it.
    add_draw(200, 5);
    add_draw(3, 4);
    add_occ(3, 4, 1'b0, 0);
    add_exp(3, 4);
    run_place("xrange", lat);
    check("xrange_latency", lat, 6);
    check("xrange_ce", ce_cnt, 2);
    check("xrange_query", query_cnt, 1);
    repeat (2) @(negedge clk);

    // Occupied cell, then a free one acknowledged after 3 wait cycles.
    add_draw(7, 7);
    add_draw(8, 7);
    add_occ(7, 7, 1'b1, 0);
    add_occ(8, 7, 1'b0, 3);
    add_exp(8, 7);
    run_place("hit", lat);
    check("hit_latency", lat, 10);
    check("hit_ce", ce_cnt, 2);
    check("hit_query", query_cnt, 2);
    repeat (2) @(negedge clk);

    // Edges of the field: x = GRID_W and y = GRID_H reject, max corner accepts.
    add_draw(160, 0);
    add_draw(0, 120);
    add_draw(159, 119);
    add_occ(159, 119, 1'b0, 0);
    add_exp(159, 119);
    run_place("bound", lat);
    check("bound_latency", lat, 8);
    check("bound_ce", ce_cnt, 3);
    check("bound_query", query_cnt, 1);
    repeat (2) @(negedge clk);

    // place pulses while busy must be dropped.
    add_draw(1, 2);
    add_occ(1, 2, 1'b0, 4);
    add_exp(1, 2);
    clear_counts();
    @(negedge clk);
    place = 1'b1;
    @(negedge clk);
    place = 1'b0;
    @(negedge clk);
    place = 1'b1;
    @(negedge clk);
    place = 1'b0;
    @(negedge clk);
    place = 1'b1;
    @(negedge clk);
    place = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_ign_done", busy, 0);
    repeat (10) @(negedge clk);
    check("busy_ign_places", place_cnt, 1);
    check("busy_ign_ce", ce_cnt, 1);
    check("busy_ign_query", query_cnt, 1);
    check("busy_ign_busy", busy, 0);

    // Reset in the middle of a query; the ack arrives afterwards.
    add_draw(9, 9);
    add_occ(9, 9, 1'b0, 6);
    clear_counts();
    @(negedge clk);
    place = 1'b1;
    @(negedge clk);
    place = 1'b0;
    n = 0;
    while (occ_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rstq_reached_query", occ_req, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstq_busy", busy, 0);
    check("rstq_occ_req", occ_req, 0);
    check("rstq_food_valid", food_valid, 0);
    check("rstq_food_x", food_x, 0);
    repeat (10) @(negedge clk);
    check("rstq_late_busy", busy, 0);
    check("rstq_late_food_valid", food_valid, 0);
    check("rstq_late_food_y", food_y, 0);
    check("rstq_late_places", place_cnt, 0);
    check("rstq_late_pending", pending, 0);

    // Normal operation resumes after the reset.
    add_draw(20, 30);
    add_occ(20, 30, 1'b0, 1);
    add_exp(20, 30);
    run_place("recover", lat);
    check("recover_latency", lat, 5);
    check("recover_food_valid", food_valid, 1);
    repeat (2) @(negedge clk);

`ifdef FOOD_RETRY_LIMIT_EN
    // Every cell occupied: MAX_TRIES (4) queries, then give up.
    for (int i = 0; i < 4; i++) begin
      add_draw(5, 5);
      add_occ(5, 5, 1'b1, 0);
    end
    run_place("limit", lat);
    repeat (3) @(negedge clk);
    check("limit_query", query_cnt, 4);
    check("limit_ce", ce_cnt, 4);
    check("limit_fail_pulses", fail_cnt, 1);
    check("limit_food_valid", food_valid, 0);
    check("limit_busy", busy, 0);
`else
    check("no_fail_ever", fail_total, 0);
`endif

    check("sb_empty", exp_q.size(), 0);
    check("occ_q_empty", occ_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
